fft32_mdc_ctrl: RTL and testbench

//  Sequencer for the 5-stage radix-2 MDC 32-point FFT pipeline: 2 samples/cycle, 16 cycles/frame.

---
 rtl/fft32_mdc_ctrl_if.sv | 41 ++++
 rtl/fft32_mdc_ctrl.sv | 101 ++++++++++
 tb/tb_fft32_mdc_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fft32_mdc_ctrl_if.sv
// Sample-side and datapath-side signals of the 32-point MDC FFT sequencer.
// Optional out_idx/out_idx_rev exist only when FFT_CTRL_OUTIDX_EN is defined.
interface fft32_mdc_ctrl_if;
  // in_valid has no back-pressure: a sample pair is consumed on every clock
  // edge where in_valid is high; in_sof only has meaning together with in_valid.
  logic       in_valid;
  logic       in_sof;
  logic [4:0] stg_valid;
  logic [3:0] tw_addr1;
  logic [3:0] tw_addr2;
  logic [3:0] tw_addr3;
  logic [3:0] tw_addr4;
  logic [3:0] sw_sel;
  logic       out_valid;
  logic       frame_done;
  logic       busy;
  logic       sync_err;
  logic [1:0] dbg_state;
`ifdef FFT_CTRL_OUTIDX_EN
  logic [3:0] out_idx;
  logic [3:0] out_idx_rev;
`endif

  modport master (
    output in_valid, in_sof,
`ifdef FFT_CTRL_OUTIDX_EN
    input  out_idx, out_idx_rev,
`endif
    input  stg_valid, tw_addr1, tw_addr2, tw_addr3, tw_addr4, sw_sel,
    input  out_valid, frame_done, busy, sync_err, dbg_state
  );

  modport slave (
    input  in_valid, in_sof,
`ifdef FFT_CTRL_OUTIDX_EN
    output out_idx, out_idx_rev,
`endif
    output stg_valid, tw_addr1, tw_addr2, tw_addr3, tw_addr4, sw_sel,
    output out_valid, frame_done, busy, sync_err, dbg_state
  );
endinterface

// File: rtl/fft32_mdc_ctrl.sv
// Sequencer for the 5-stage radix-2 MDC 32-point FFT: valid/sof chains, per-stage
// frame counters, twiddle addresses, commutator selects, IDLE/RUN/FLUSH status.
// Define FFT_CTRL_OUTIDX_EN to add out_idx/out_idx_rev.
module fft32_mdc_ctrl #(
  parameter int STAGE_LAT = 2,
  parameter int CNT_W     = 4
) (
  input logic            clk,
  input logic            rst,
  fft32_mdc_ctrl_if.slave bus
);
  localparam int VCH_W = 5 * STAGE_LAT;
  localparam int SCH_W = 4 * STAGE_LAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [VCH_W-1:0] r_vsh;
  logic [SCH_W-1:0] r_ssh;
  logic [CNT_W-1:0] r_cnt [5];
  logic [CNT_W-1:0] r_oidx [STAGE_LAT];
  logic             r_wrap;
  logic             r_sync_err;

  logic [5:0]       w_v;
  logic [4:0]       w_sof;
  logic [CNT_W-1:0] w_idx [5];
  logic             w_fd;
  logic             w_chain_empty;
  logic             w_sync;
  logic             w_wrap;

  // A pair carrying the sof marker is index 0 at that stage regardless of the counter.
  always_comb begin
    w_v[0]   = bus.in_valid;
    w_sof[0] = bus.in_valid & bus.in_sof;
    for (int s = 1; s <= 5; s++) w_v[s] = r_vsh[s*STAGE_LAT-1];
    for (int s = 1; s <= 4; s++) w_sof[s] = r_ssh[s*STAGE_LAT-1];
    for (int s = 0; s < 5; s++) w_idx[s] = w_sof[s] ? '0 : r_cnt[s];
  end

  assign w_fd          = w_v[5] && (r_oidx[STAGE_LAT-1] == {CNT_W{1'b1}});
  assign w_chain_empty = !bus.in_valid && (r_vsh[VCH_W-2:0] == '0);
  assign w_sync        = w_sof[0] && (r_cnt[0] != '0);
  assign w_wrap        = w_v[0] && (w_idx[0] == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsh      <= '0;
      r_ssh      <= '0;
      for (int s = 0; s < 5; s++) r_cnt[s] <= '0;
      for (int k = 0; k < STAGE_LAT; k++) r_oidx[k] <= '0;
      r_wrap     <= 1'b0;
      r_sync_err <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_vsh <= {r_vsh[VCH_W-2:0], bus.in_valid};
      r_ssh <= {r_ssh[SCH_W-2:0], w_sof[0]};
      for (int s = 0; s < 5; s++) begin
        if (w_v[s]) r_cnt[s] <= w_idx[s] + 1'b1;
      end
      // Stage-5 position travels with the data so it lines up with out_valid.
      r_oidx[0] <= w_idx[4];
      for (int k = 1; k < STAGE_LAT; k++) r_oidx[k] <= r_oidx[k-1];
      r_wrap     <= w_wrap;
      r_sync_err <= w_sync;
      case (r_state)
        IDLE:    if (bus.in_valid) r_state <= RUN;
        RUN:     if (r_wrap && !bus.in_valid) r_state <= FLUSH;
        FLUSH: begin
          if (bus.in_valid) r_state <= RUN;
          else if (w_fd && w_chain_empty) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stg_valid  = w_v[4:0];
  assign bus.out_valid  = w_v[5];
  assign bus.tw_addr1   = w_idx[0];
  assign bus.tw_addr2   = {w_idx[1][2:0], 1'b0};
  assign bus.tw_addr3   = {w_idx[2][1:0], 2'b00};
  assign bus.tw_addr4   = {w_idx[3][0], 3'b000};
  assign bus.sw_sel     = {w_idx[3][0], w_idx[2][1], w_idx[1][2], w_idx[0][3]};
  assign bus.frame_done = w_fd;
  assign bus.busy       = (r_state != IDLE);
  assign bus.sync_err   = r_sync_err;
  assign bus.dbg_state  = r_state;

`ifdef FFT_CTRL_OUTIDX_EN
  logic [3:0] w_oidx;
  assign w_oidx          = w_v[5] ? r_oidx[STAGE_LAT-1] : 4'd0;
  assign bus.out_idx     = w_oidx;
  assign bus.out_idx_rev = {w_oidx[0], w_oidx[1], w_oidx[2], w_oidx[3]};
`endif
endmodule

// File: tb/tb_fft32_mdc_ctrl.sv
// Directed bench for fft32_mdc_ctrl (STAGE_LAT=2): single frame, back-to-back,
// gap, misaligned sof and mid-frame reset.
module tb_fft32_mdc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fft32_mdc_ctrl_if bus();

  fft32_mdc_ctrl #(.STAGE_LAT(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int ov_cnt = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  int fd_cyc[$];
  int fd_ov[$];
  logic [9:0] m_vh = '0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sof   = s;
    rst          = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0);
    #2;
  endtask

  function automatic logic [3:0] eidx(input int i, input int s);
    int j;
    j = i - 2 * (s - 1);
    return (j >= 0 && j < 16) ? 4'(j) : 4'd0;
  endfunction

  function automatic logic ev(input int i, input int s);
    int j;
    j = i - 2 * (s - 1);
    return (j >= 0 && j < 16);
  endfunction

  // out_valid must repeat in_valid exactly 10 cycles later; reset clears history.
  always @(negedge clk) begin
    cyc_n++;
    if (mon_en) begin
      chk("lat_out_valid", 32'(bus.out_valid), 32'(m_vh[9]));
      if (bus.out_valid) ov_cnt++;
      if (bus.frame_done) begin
        fd_cnt++;
        fd_cyc.push_back(cyc_n);
        fd_ov.push_back(ov_cnt);
      end
      if (bus.sync_err) se_cnt++;
    end
    m_vh = rst ? 10'd0 : {m_vh[8:0], bus.in_valid};
  end

  initial begin
    logic [3:0] e1, e2, e3, e4;
    int fd0, ov0, se0, sz;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    chk("rst_stg_valid", 32'(bus.stg_valid), 0);
    chk("rst_tw_addr1", 32'(bus.tw_addr1), 0);
    chk("rst_sw_sel", 32'(bus.sw_sel), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_state", 32'(bus.dbg_state), 0);

    // single frame
    for (int i = 0; i < 26; i++) begin
      drive(i < 16, i == 0, 1'b0);
      e1 = eidx(i, 1); e2 = eidx(i, 2); e3 = eidx(i, 3); e4 = eidx(i, 4);
      chk("t1_tw_addr1", 32'(bus.tw_addr1), 32'(e1));
      chk("t1_tw_addr2", 32'(bus.tw_addr2), 32'({e2[2:0], 1'b0}));
      chk("t1_tw_addr3", 32'(bus.tw_addr3), 32'({e3[1:0], 2'b00}));
      chk("t1_tw_addr4", 32'(bus.tw_addr4), 32'({e4[0], 3'b000}));
      chk("t1_sw_sel", 32'(bus.sw_sel), 32'({e4[0], e3[1], e2[2], e1[3]}));
      chk("t1_stg_valid", 32'(bus.stg_valid),
          32'({ev(i, 5), ev(i, 4), ev(i, 3), ev(i, 2), ev(i, 1)}));
      chk("t1_out_valid", 32'(bus.out_valid), 32'(ev(i, 6)));
      chk("t1_frame_done", 32'(bus.frame_done), 32'(i == 25));
      chk("t1_busy", 32'(bus.busy), 32'(i >= 1));
      chk("t1_sync_err", 32'(bus.sync_err), 0);
`ifdef FFT_CTRL_OUTIDX_EN
      e1 = eidx(i, 6);
      chk("t1_out_idx", 32'(bus.out_idx), 32'(e1));
      chk("t1_out_idx_rev", 32'(bus.out_idx_rev), 32'({e1[0], e1[1], e1[2], e1[3]}));
`endif
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("t1_busy_end", 32'(bus.busy), 0);
    chk("t1_state_end", 32'(bus.dbg_state), 0);

    // two back-to-back frames
    #2;
    fd0 = fd_cnt; ov0 = ov_cnt; se0 = se_cnt;
    for (int i = 0; i < 32; i++) drive(1'b1, i == 0 || i == 16, 1'b0);
    idle(30);
    sz = fd_cyc.size();
    chk("t2_fd_count", 32'(fd_cnt - fd0), 2);
    chk("t2_fd_spacing", (sz >= 2) ? 32'(fd_cyc[sz-1] - fd_cyc[sz-2]) : 32'd0, 16);
    chk("t2_ov_count", 32'(ov_cnt - ov0), 32);
    chk("t2_sync_err", 32'(se_cnt - se0), 0);
    chk("t2_busy_end", 32'(bus.busy), 0);

    // gap on input cycles 5..7
    fd0 = fd_cnt; ov0 = ov_cnt;
    for (int c = 0; c < 19; c++) begin
      drive(!(c >= 5 && c <= 7), c == 0, 1'b0);
      if (c == 4) chk("t3_tw_addr1_pre", 32'(bus.tw_addr1), 4);
      if (c >= 5 && c <= 8) chk("t3_tw_addr1_hold", 32'(bus.tw_addr1), 5);
      if (c >= 5 && c <= 7) chk("t3_sw_sel0_hold", 32'(bus.sw_sel[0]), 0);
      if (c == 12) chk("t3_sw_sel0_idx9", 32'(bus.sw_sel[0]), 1);
    end
    idle(30);
    chk("t3_fd_count", 32'(fd_cnt - fd0), 1);
    chk("t3_ov_count", 32'(ov_cnt - ov0), 16);
    chk("t3_busy_end", 32'(bus.busy), 0);

    // misaligned sof at cnt_1 = 9
    fd0 = fd_cnt; ov0 = ov_cnt; se0 = se_cnt;
    for (int i = 0; i < 9; i++) drive(1'b1, i == 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("t4_tw_addr1_next", 32'(bus.tw_addr1), 1);
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, 1'b0);
    idle(30);
    sz = fd_ov.size();
    chk("t4_sync_err_count", 32'(se_cnt - se0), 1);
    chk("t4_fd_count", 32'(fd_cnt - fd0), 1);
    chk("t4_ov_count", 32'(ov_cnt - ov0), 25);
    chk("t4_fd_at_ov", (sz >= 1) ? 32'(fd_ov[sz-1] - ov0) : 32'd0, 25);
    chk("t4_busy_end", 32'(bus.busy), 0);

    // reset mid-frame at cnt_1 = 7
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    chk("t5_tw_addr1_pre", 32'(bus.tw_addr1), 7);
    #2;
    fd0 = fd_cnt; ov0 = ov_cnt;
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_stg_valid", 32'(bus.stg_valid), 0);
    chk("t5_tw_addrs", 32'({bus.tw_addr1, bus.tw_addr2, bus.tw_addr3, bus.tw_addr4}), 0);
    chk("t5_sw_sel", 32'(bus.sw_sel), 0);
    chk("t5_status", 32'({bus.out_valid, bus.frame_done, bus.busy, bus.sync_err}), 0);
    chk("t5_state", 32'(bus.dbg_state), 0);
    idle(30);
    chk("t5_no_fd", 32'(fd_cnt - fd0), 0);
    chk("t5_no_ov", 32'(ov_cnt - ov0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
